// File: rtl/tm_shell_pkg.sv
// Shared types and sizing helpers for the slave-side credit shell.
// tm_dst_t is the reply return address {vc, dest} at the default NoC widths.
package tm_shell_pkg;

    localparam int TM_ADDRESS_WIDTH    = 4;
    localparam int TM_VC_ADDRESS_WIDTH = 2;
    localparam int DST_WIDTH           = TM_ADDRESS_WIDTH + TM_VC_ADDRESS_WIDTH;

    typedef struct packed {
        logic [TM_VC_ADDRESS_WIDTH-1:0] vc;
        logic [TM_ADDRESS_WIDTH-1:0]    dest;
    } tm_dst_t;

    // Occupancy counter must represent 0..depth inclusive.
    function automatic int tm_count_width(input int depth);
        return $clog2(depth + 1);
    endfunction

    function automatic int tm_ptr_width(input int depth);
        return (depth > 1) ? $clog2(depth) : 1;
    endfunction

endpackage

// File: rtl/tm_tag_fifo.sv
// In-order FIFO of reply return addresses. Head is a registered read of the
// storage array, refreshed on every push/pop so it is ready as soon as count != 0.
module tm_tag_fifo
    import tm_shell_pkg::*;
#(
    parameter int DEPTH = 32,
    parameter int WIDTH = DST_WIDTH,
    localparam int CW   = tm_count_width(DEPTH),
    localparam int PW   = tm_ptr_width(DEPTH)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push_i,
    input  logic [WIDTH-1:0] push_data_i,
    input  logic             pop_i,
    output logic [WIDTH-1:0] head_o,
    output logic [CW-1:0]    count_o
);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [PW-1:0]    wr_ptr_q, wr_ptr_d;
    logic [PW-1:0]    rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]    count_q, count_d;
    logic [WIDTH-1:0] head_q, head_d;

    function automatic logic [PW-1:0] next_ptr(input logic [PW-1:0] p);
        return (p == PW'(DEPTH - 1)) ? '0 : p + PW'(1);
    endfunction

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (push_i) begin
            wr_ptr_d = next_ptr(wr_ptr_q);
        end
        if (pop_i) begin
            rd_ptr_d = next_ptr(rd_ptr_q);
        end
        case ({push_i, pop_i})
            2'b10:   count_d = count_q + CW'(1);
            2'b01:   count_d = count_q - CW'(1);
            default: count_d = count_q;
        endcase
        // Bypass when the entry becoming head is the one being written this cycle.
        head_d = (push_i && (wr_ptr_q == rd_ptr_d)) ? push_data_i : mem_q[rd_ptr_d];
    end

    always_ff @(posedge clk) begin
        if (push_i) begin
            mem_q[wr_ptr_q] <= push_data_i;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            head_q   <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            head_q   <= head_d;
        end
    end

    always @(posedge clk) begin
        if (!rst) begin
            assert (!(push_i && !pop_i && (count_q == CW'(DEPTH))))
                else $error("tm_tag_fifo: push while full");
            assert (!(pop_i && (count_q == '0)))
                else $error("tm_tag_fifo: pop while empty");
        end
    end

    assign head_o  = head_q;
    assign count_o = count_q;

endmodule

// File: rtl/tm_slave_multimaster.sv
// Slave-end credit shell: request skid buffer toward the slave, tag FIFO of
// return addresses, and a one-entry reply register stamped with the oldest tag.
module tm_slave_multimaster
    import tm_shell_pkg::*;
#(
    parameter int NUM_CREDITS      = 32,
    parameter int ADDRESS_WIDTH    = TM_ADDRESS_WIDTH,
    parameter int VC_ADDRESS_WIDTH = TM_VC_ADDRESS_WIDTH,
    parameter int WIDTH_DATA       = 36,
    localparam int CW              = tm_count_width(NUM_CREDITS)
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        req_valid_in,
    input  logic [WIDTH_DATA-1:0]       req_data_in,
    input  logic [ADDRESS_WIDTH-1:0]    req_src_in,
    input  logic [VC_ADDRESS_WIDTH-1:0] req_vc_in,
    output logic                        req_ready_out,
    output logic                        req_valid_out,
    output logic [WIDTH_DATA-1:0]       req_data_out,
    input  logic                        req_ready_in,
    input  logic                        reply_valid_in,
    input  logic [WIDTH_DATA-1:0]       reply_data_in,
    output logic                        reply_ready_out,
    output logic                        reply_valid_out,
    output logic [WIDTH_DATA-1:0]       reply_data_out,
    output logic [ADDRESS_WIDTH-1:0]    reply_dest_out,
    output logic [VC_ADDRESS_WIDTH-1:0] reply_vc_out,
    input  logic                        reply_ready_in,
    output logic [CW-1:0]               outstanding_count
);

    localparam int TW = ADDRESS_WIDTH + VC_ADDRESS_WIDTH;

    logic                        main_valid_q, main_valid_d;
    logic [WIDTH_DATA-1:0]       main_data_q, main_data_d;
    logic                        ovf_valid_q, ovf_valid_d;
    logic [WIDTH_DATA-1:0]       ovf_data_q, ovf_data_d;
    logic                        rep_valid_q, rep_valid_d;
    logic [WIDTH_DATA-1:0]       rep_data_q, rep_data_d;
    logic [ADDRESS_WIDTH-1:0]    rep_dest_q, rep_dest_d;
    logic [VC_ADDRESS_WIDTH-1:0] rep_vc_q, rep_vc_d;

    logic          req_accept;
    logic          main_drain;
    logic          reply_accept;
    logic [CW-1:0] fifo_count;
    logic [TW-1:0] fifo_head;

    // Both terms are register outputs, so no input reaches req_ready_out.
    assign req_ready_out   = ~ovf_valid_q & (fifo_count < CW'(NUM_CREDITS));
    assign req_accept      = req_valid_in & req_ready_out;
    assign main_drain      = main_valid_q & req_ready_in;
    assign reply_ready_out = (fifo_count != '0) & (~rep_valid_q | reply_ready_in);
    assign reply_accept    = reply_valid_in & reply_ready_out;

    tm_tag_fifo #(
        .DEPTH (NUM_CREDITS),
        .WIDTH (TW)
    ) u_tag_fifo (
        .clk         (clk),
        .rst         (rst),
        .push_i      (req_accept),
        .push_data_i ({req_vc_in, req_src_in}),
        .pop_i       (reply_accept),
        .head_o      (fifo_head),
        .count_o     (fifo_count)
    );

    always_comb begin
        main_valid_d = main_valid_q;
        main_data_d  = main_data_q;
        ovf_valid_d  = ovf_valid_q;
        ovf_data_d   = ovf_data_q;
        if (ovf_valid_q) begin
            // No accept is possible here; only the overflow-to-main shift.
            if (main_drain) begin
                main_valid_d = 1'b1;
                main_data_d  = ovf_data_q;
                ovf_valid_d  = 1'b0;
            end
        end else if (!main_valid_q || main_drain) begin
            main_valid_d = req_accept;
            if (req_accept) begin
                main_data_d = req_data_in;
            end
        end else if (req_accept) begin
            ovf_valid_d = 1'b1;
            ovf_data_d  = req_data_in;
        end
    end

    always_comb begin
        rep_valid_d = rep_valid_q;
        rep_data_d  = rep_data_q;
        rep_dest_d  = rep_dest_q;
        rep_vc_d    = rep_vc_q;
        if (reply_ready_in) begin
            rep_valid_d = 1'b0;
        end
        if (reply_accept) begin
            rep_valid_d = 1'b1;
            rep_data_d  = reply_data_in;
            rep_dest_d  = fifo_head[ADDRESS_WIDTH-1:0];
            rep_vc_d    = fifo_head[TW-1:ADDRESS_WIDTH];
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            main_valid_q <= 1'b0;
            main_data_q  <= '0;
            ovf_valid_q  <= 1'b0;
            ovf_data_q   <= '0;
            rep_valid_q  <= 1'b0;
            rep_data_q   <= '0;
            rep_dest_q   <= '0;
            rep_vc_q     <= '0;
        end else begin
            main_valid_q <= main_valid_d;
            main_data_q  <= main_data_d;
            ovf_valid_q  <= ovf_valid_d;
            ovf_data_q   <= ovf_data_d;
            rep_valid_q  <= rep_valid_d;
            rep_data_q   <= rep_data_d;
            rep_dest_q   <= rep_dest_d;
            rep_vc_q     <= rep_vc_d;
        end
    end

    assign req_valid_out     = main_valid_q;
    assign req_data_out      = main_data_q;
    assign reply_valid_out   = rep_valid_q;
    assign reply_data_out    = rep_data_q;
    assign reply_dest_out    = rep_dest_q;
    assign reply_vc_out      = rep_vc_q;
    assign outstanding_count = fifo_count;

endmodule

// File: tb/tb_tm_slave_multimaster.sv
// Bench for tm_slave_multimaster with NUM_CREDITS=4: queue-based model checked
// every cycle, plus directed scenarios with literal expectations.
module tb_tm_slave_multimaster;

    localparam int NC = 4;
    localparam int AW = 4;
    localparam int VW = 2;
    localparam int WD = 36;
    localparam int CW = $clog2(NC + 1);

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          req_valid_in = 1'b0;
    logic [WD-1:0] req_data_in = '0;
    logic [AW-1:0] req_src_in = '0;
    logic [VW-1:0] req_vc_in = '0;
    logic          req_ready_out;
    logic          req_valid_out;
    logic [WD-1:0] req_data_out;
    logic          req_ready_in = 1'b0;
    logic          reply_valid_in = 1'b0;
    logic [WD-1:0] reply_data_in = '0;
    logic          reply_ready_out;
    logic          reply_valid_out;
    logic [WD-1:0] reply_data_out;
    logic [AW-1:0] reply_dest_out;
    logic [VW-1:0] reply_vc_out;
    logic          reply_ready_in = 1'b0;
    logic [CW-1:0] outstanding_count;

    int checks = 0;
    int errors = 0;
    bit cmp_en = 1'b0;

    always #5 clk = ~clk;

    tm_slave_multimaster #(
        .NUM_CREDITS      (NC),
        .ADDRESS_WIDTH    (AW),
        .VC_ADDRESS_WIDTH (VW),
        .WIDTH_DATA       (WD)
    ) dut (
        .clk               (clk),
        .rst               (rst),
        .req_valid_in      (req_valid_in),
        .req_data_in       (req_data_in),
        .req_src_in        (req_src_in),
        .req_vc_in         (req_vc_in),
        .req_ready_out     (req_ready_out),
        .req_valid_out     (req_valid_out),
        .req_data_out      (req_data_out),
        .req_ready_in      (req_ready_in),
        .reply_valid_in    (reply_valid_in),
        .reply_data_in     (reply_data_in),
        .reply_ready_out   (reply_ready_out),
        .reply_valid_out   (reply_valid_out),
        .reply_data_out    (reply_data_out),
        .reply_dest_out    (reply_dest_out),
        .reply_vc_out      (reply_vc_out),
        .reply_ready_in    (reply_ready_in),
        .outstanding_count (outstanding_count)
    );

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Model: flits held for the slave, outstanding return addresses, reply register.
    logic [WD-1:0]      m_req [$];
    logic [AW+VW-1:0]   m_tag [$];
    logic [WD+AW+VW-1:0] m_out [$];

    always @(posedge clk or posedge rst) begin
        bit acc, drain, pop, outgo;
        logic [AW+VW-1:0] tag;
        if (rst) begin
            m_req.delete();
            m_tag.delete();
            m_out.delete();
        end else begin
            acc   = req_valid_in && (m_req.size() < 2) && (m_tag.size() < NC);
            drain = (m_req.size() > 0) && req_ready_in;
            pop   = reply_valid_in && (m_tag.size() != 0) && ((m_out.size() == 0) || reply_ready_in);
            outgo = (m_out.size() > 0) && reply_ready_in;
            if (drain) void'(m_req.pop_front());
            if (acc) begin
                m_req.push_back(req_data_in);
                m_tag.push_back({req_vc_in, req_src_in});
                $display("req   accept data=%0h src=%0d vc=%0d", req_data_in, req_src_in, req_vc_in);
            end
            if (outgo) void'(m_out.pop_front());
            if (pop) begin
                tag = m_tag.pop_front();
                m_out.push_back({reply_data_in, tag});
                $display("reply accept data=%0h dest=%0d vc=%0d", reply_data_in, tag[AW-1:0], tag[AW+VW-1:AW]);
            end
        end
    end

    always @(negedge clk) begin
        if (!rst && cmp_en) begin
            chk("count", 64'(outstanding_count), 64'(m_tag.size()));
            chk("req_ready_out", 64'(req_ready_out), 64'((m_req.size() < 2) && (m_tag.size() < NC)));
            chk("req_valid_out", 64'(req_valid_out), 64'(m_req.size() > 0));
            if (m_req.size() > 0) chk("req_data_out", 64'(req_data_out), 64'(m_req[0]));
            chk("reply_valid_out", 64'(reply_valid_out), 64'(m_out.size() > 0));
            if (m_out.size() > 0)
                chk("reply_flit", 64'({reply_data_out, reply_vc_out, reply_dest_out}), 64'(m_out[0]));
            chk("reply_ready_out", 64'(reply_ready_out),
                64'((m_tag.size() != 0) && ((m_out.size() == 0) || reply_ready_in)));
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive_req(input logic [AW-1:0] src, input logic [VW-1:0] vc, input logic [WD-1:0] data);
        req_valid_in = 1'b1;
        req_src_in   = src;
        req_vc_in    = vc;
        req_data_in  = data;
    endtask

    initial begin
        int n;
        bit rdy;
        #1;
        chk("rst_req_valid", 64'(req_valid_out), 64'd0);
        chk("rst_reply_valid", 64'(reply_valid_out), 64'd0);
        chk("rst_count", 64'(outstanding_count), 64'd0);
        chk("rst_reply_fields", 64'({reply_data_out, reply_dest_out, reply_vc_out}), 64'd0);
        chk("rst_req_data", 64'(req_data_out), 64'd0);
        step();
        step();
        rst    = 1'b0;
        cmp_en = 1'b1;

        // 1: single flit round trip
        drive_req(4'd3, 2'd1, 36'hA5);
        step();
        req_valid_in = 1'b0;
        chk("t1_req_valid", 64'(req_valid_out), 64'd1);
        chk("t1_req_data", 64'(req_data_out), 64'hA5);
        chk("t1_count1", 64'(outstanding_count), 64'd1);
        req_ready_in = 1'b1;
        step();
        req_ready_in = 1'b0;
        chk("t1_req_drained", 64'(req_valid_out), 64'd0);
        reply_valid_in = 1'b1;
        reply_data_in  = 36'h5A;
        step();
        reply_valid_in = 1'b0;
        chk("t1_reply_valid", 64'(reply_valid_out), 64'd1);
        chk("t1_reply_dest", 64'(reply_dest_out), 64'd3);
        chk("t1_reply_vc", 64'(reply_vc_out), 64'd1);
        chk("t1_reply_data", 64'(reply_data_out), 64'h5A);
        chk("t1_count0", 64'(outstanding_count), 64'd0);
        reply_ready_in = 1'b1;
        step();

        // 2: three masters, in-order replies
        req_ready_in = 1'b1;
        for (int s = 1; s <= 3; s++) begin
            drive_req(AW'(s), VW'(s - 1), 36'h100 + 36'(s));
            step();
        end
        req_valid_in = 1'b0;
        step();
        for (int i = 0; i < 3; i++) begin
            reply_valid_in = 1'b1;
            reply_data_in  = 36'h200 + 36'(i);
            step();
            chk("t2_reply_dest", 64'(reply_dest_out), 64'(i + 1));
        end
        reply_valid_in = 1'b0;
        step();
        chk("t2_count0", 64'(outstanding_count), 64'd0);

        // 3: credit limit
        n = 0;
        for (int c = 0; c < 6; c++) begin
            drive_req(4'd2, 2'd0, 36'h300 + 36'(n));
            rdy = req_ready_out;
            step();
            if (rdy) n++;
        end
        req_valid_in = 1'b0;
        chk("t3_accepted", 64'(n), 64'd4);
        chk("t3_count4", 64'(outstanding_count), 64'd4);
        chk("t3_ready_low", 64'(req_ready_out), 64'd0);
        reply_valid_in = 1'b1;
        reply_data_in  = 36'h3F0;
        step();
        chk("t3_count3", 64'(outstanding_count), 64'd3);
        chk("t3_ready_high", 64'(req_ready_out), 64'd1);
        step();
        step();
        step();
        reply_valid_in = 1'b0;
        step();
        chk("t3_count0", 64'(outstanding_count), 64'd0);

        // 4: slave backpressure
        req_ready_in = 1'b0;
        n = 0;
        for (int c = 0; c < 4; c++) begin
            drive_req(4'd4, 2'd2, 36'h400 + 36'(n));
            rdy = req_ready_out;
            step();
            if (rdy) n++;
        end
        req_valid_in = 1'b0;
        chk("t4_accepted", 64'(n), 64'd2);
        chk("t4_ready_low", 64'(req_ready_out), 64'd0);
        chk("t4_head", 64'(req_data_out), 64'h400);
        req_ready_in = 1'b1;
        step();
        chk("t4_second", 64'(req_data_out), 64'h401);
        chk("t4_second_valid", 64'(req_valid_out), 64'd1);
        step();
        chk("t4_empty", 64'(req_valid_out), 64'd0);
        reply_valid_in = 1'b1;
        step();
        step();
        reply_valid_in = 1'b0;
        step();

        // 5: NoC backpressure
        drive_req(4'd5, 2'd2, 36'h500);
        step();
        drive_req(4'd6, 2'd3, 36'h600);
        step();
        req_valid_in = 1'b0;
        step();
        reply_ready_in = 1'b0;
        reply_valid_in = 1'b1;
        reply_data_in  = 36'hAAA;
        step();
        reply_data_in  = 36'hBBB;
        for (int c = 0; c < 5; c++) begin
            step();
            chk("t5_hold_dest", 64'(reply_dest_out), 64'd5);
            chk("t5_hold_data", 64'(reply_data_out), 64'hAAA);
            chk("t5_ready_low", 64'(reply_ready_out), 64'd0);
            chk("t5_count1", 64'(outstanding_count), 64'd1);
        end
        reply_ready_in = 1'b1;
        step();
        chk("t5_next_dest", 64'(reply_dest_out), 64'd6);
        chk("t5_next_data", 64'(reply_data_out), 64'hBBB);
        reply_valid_in = 1'b0;
        step();

        // 6: simultaneous push/pop, then reset mid-burst
        drive_req(4'd7, 2'd0, 36'h700);
        step();
        drive_req(4'd8, 2'd1, 36'h800);
        step();
        chk("t6_count2", 64'(outstanding_count), 64'd2);
        drive_req(4'd9, 2'd2, 36'h900);
        reply_valid_in = 1'b1;
        reply_data_in  = 36'hC00;
        step();
        chk("t6_push_pop", 64'(outstanding_count), 64'd2);
        step();
        @(posedge clk);
        #3;
        rst = 1'b1;
        #1;
        chk("t6_rst_req_valid", 64'(req_valid_out), 64'd0);
        chk("t6_rst_reply_valid", 64'(reply_valid_out), 64'd0);
        chk("t6_rst_count", 64'(outstanding_count), 64'd0);
        req_valid_in   = 1'b0;
        reply_valid_in = 1'b0;
        step();
        rst = 1'b0;
        chk("t6_ready_after", 64'(req_ready_out), 64'd1);
        step();
        chk("t6_idle_valid", 64'(req_valid_out), 64'd0);
        chk("t6_idle_count", 64'(outstanding_count), 64'd0);
        step();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
